// File: rtl/ila_pkg.sv
// ila_pkg: definitions shared by the ILA blocks.
//   - 3-bit capture FSM state encodings.
//   - depth_of(): buffer depth in samples for a given address width.
package ila_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_ARMED = 3'd2;
  localparam logic [2:0] ST_POST  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/ila_ram_sdp.sv
// ila_ram_sdp: single-clock simple-dual-port RAM, inferrable as block RAM.
// Ports:
//   clk      clock for both ports
//   we       write enable
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address
//   rd_data  registered read data (read-during-write returns old contents)
module ila_ram_sdp
  import ila_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ila_trigger_buffer.sv
// ila_trigger_buffer: ILA capture buffer with trigger, programmable
// pre-trigger depth and read-out by logical index (0 = oldest sample).
// Ports:
//   clk        sole clock
//   rst        asynchronous active-high reset
//   start      single-cycle pulse, arms a new capture (ignored while busy)
//   trigger    trigger condition, sampled every cycle
//   pre_trig   samples kept before the trigger sample, latched on start
//   di         probe sample
//   rd_addr    logical read index, 0 = oldest
//   rd_data    registered read data, one cycle latency
//   busy       capture in progress
//   done       capture complete, buffer frozen
//   trig_seen  trigger accepted in the current capture
module ila_trigger_buffer
  import ila_pkg::*;
#(
  parameter int DATA_WIDTH             = 32,
  parameter int ADDR_WIDTH             = 9,
  parameter int SIGNAL_SYNCHRONISATION = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  trigger,
  input  logic [ADDR_WIDTH-1:0] pre_trig,
  input  logic [DATA_WIDTH-1:0] di,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  trig_seen
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  // di and trigger travel through identical chains so each trigger stays
  // aligned with the sample it was presented with.
  logic [DATA_WIDTH-1:0] di_s;
  logic                  trig_s;

  generate
    if (SIGNAL_SYNCHRONISATION == 0) begin : g_nosync
      assign di_s   = di;
      assign trig_s = trigger;
    end else begin : g_sync
      localparam int SYNC = SIGNAL_SYNCHRONISATION;
      logic [DATA_WIDTH-1:0] di_pipe [SYNC];
      logic [SYNC-1:0]       trig_pipe;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC; i++) begin
            di_pipe[i] <= '0;
          end
          trig_pipe <= '0;
        end else begin
          di_pipe[0]   <= di;
          trig_pipe[0] <= trigger;
          for (int i = 1; i < SYNC; i++) begin
            di_pipe[i]   <= di_pipe[i-1];
            trig_pipe[i] <= trig_pipe[i-1];
          end
        end
      end

      assign di_s   = di_pipe[SYNC-1];
      assign trig_s = trig_pipe[SYNC-1];
    end
  endgenerate

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] fill_cnt;
  logic [ADDR_WIDTH-1:0] fill_next;
  logic [ADDR_WIDTH-1:0] post_cnt;
  logic [ADDR_WIDTH-1:0] pre_q;
  logic [ADDR_WIDTH-1:0] trig_ptr;
  logic                  we;
  logic [ADDR_WIDTH-1:0] rd_phys;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  rd_valid;

  assign fill_next = fill_cnt + 1'b1;
  assign we        = (state == ST_FILL) || (state == ST_ARMED) || (state == ST_POST);
  assign busy      = we;
  assign done      = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      post_cnt  <= '0;
      pre_q     <= '0;
      trig_ptr  <= '0;
      trig_seen <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            pre_q     <= pre_trig;
            trig_seen <= 1'b0;
            // With no pre-trigger samples the fill phase is skipped entirely.
            state     <= (pre_trig == '0) ? ST_ARMED : ST_FILL;
          end
        end
        ST_FILL: begin
          wr_ptr   <= wr_ptr + 1'b1;
          fill_cnt <= fill_next;
          if (fill_next == pre_q) begin
            state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (trig_s) begin
            trig_ptr  <= wr_ptr;
            post_cnt  <= LAST - pre_q;
            trig_seen <= 1'b1;
            // A full pre-trigger window leaves nothing to capture afterwards.
            state     <= (pre_q == LAST) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          wr_ptr   <= wr_ptr + 1'b1;
          post_cnt <= post_cnt - 1'b1;
          if (post_cnt == ADDR_WIDTH'(1)) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Oldest sample sits pre_q slots behind the trigger sample; wraps naturally.
  assign rd_phys = trig_ptr - pre_q + rd_addr;

  ila_ram_sdp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we     (we),
    .wr_addr(wr_ptr),
    .wr_data(di_s),
    .rd_addr(rd_phys),
    .rd_data(ram_q)
  );

  // The RAM output register carries no reset so it maps onto the block RAM;
  // this flag forces rd_data to zero from reset until the first read edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b1;
    end
  end

  assign rd_data = rd_valid ? ram_q : '0;

endmodule

// File: tb/tb_ila_trigger_buffer.sv
module tb_ila_trigger_buffer;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          trigger;
  logic [AW-1:0] pre_trig;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] di;
  logic [DW-1:0] rd0, rd2;
  logic          busy0, done0, ts0, busy2, done2, ts2;

  int total = 0;
  int bad   = 0;
  int trig_lo = 1000;
  int trig_hi = -1000;

  always #5 clk = ~clk;

  ila_trigger_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIGNAL_SYNCHRONISATION(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .trigger(trigger), .pre_trig(pre_trig),
    .di(di), .rd_addr(rd_addr), .rd_data(rd0), .busy(busy0), .done(done0), .trig_seen(ts0)
  );

  ila_trigger_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIGNAL_SYNCHRONISATION(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .trigger(trigger), .pre_trig(pre_trig),
    .di(di), .rd_addr(rd_addr), .rd_data(rd2), .busy(busy2), .done(done2), .trig_seen(ts2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Inputs are logged per clock edge; a capture is a list of written samples.
  // The frozen buffer holds the DEPTH writes starting pre samples before the
  // trigger write, so logical index a is write number trig - pre + a.
  int          ec = 0;
  int          rst_ec = 0;
  logic [31:0] h_di [64];
  logic        h_tr [64];
  int          sync_of [2] = '{0, 2};
  bit          m_act [2];
  bit          m_done [2];
  int          m_trig [2];
  int          m_nw [2];
  int          m_pre [2];
  logic [31:0] wlog [2][1024];

  always @(posedge clk) begin : compare
    logic [31:0] exp_rd [2];
    bit          exp_v [2];
    logic [31:0] dv;
    logic        tv;
    int          s;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k]  = 0;
        m_done[k] = 0;
        m_trig[k] = -1;
        m_nw[k]   = 0;
        exp_v[k]  = 1;
        exp_rd[k] = '0;
      end
      rst_ec = ec + 1;
    end else begin
      h_di[ec % 64] = di;
      h_tr[ec % 64] = trigger;
      for (int k = 0; k < 2; k++) begin
        exp_v[k] = m_act[k] && m_done[k];
        exp_rd[k] = '0;
        if (exp_v[k]) exp_rd[k] = wlog[k][m_trig[k] - m_pre[k] + int'(rd_addr)];
        if (m_act[k] && !m_done[k]) begin
          s = sync_of[k];
          if (ec - s >= rst_ec) begin
            dv = h_di[(ec - s) % 64];
            tv = h_tr[(ec - s) % 64];
          end else begin
            dv = '0;
            tv = 1'b0;
          end
          if (m_nw[k] < 1024) wlog[k][m_nw[k]] = dv;
          if (m_trig[k] < 0 && m_nw[k] >= m_pre[k] && tv) m_trig[k] = m_nw[k];
          m_nw[k]++;
          if (m_trig[k] >= 0 && m_nw[k] == m_trig[k] + DEPTH - m_pre[k]) m_done[k] = 1;
        end else if (start) begin
          m_act[k]  = 1;
          m_done[k] = 0;
          m_trig[k] = -1;
          m_nw[k]   = 0;
          m_pre[k]  = int'(pre_trig);
        end
      end
    end
    ec++;
    #1;
    chk("m busy0", busy0, m_act[0] && !m_done[0]);
    chk("m done0", done0, m_act[0] && m_done[0]);
    chk("m trig_seen0", ts0, m_act[0] && m_trig[0] >= 0);
    chk("m busy2", busy2, m_act[1] && !m_done[1]);
    chk("m done2", done2, m_act[1] && m_done[1]);
    chk("m trig_seen2", ts2, m_act[1] && m_trig[1] >= 0);
    if (exp_v[0]) chk("m rd_data0", rd0, exp_rd[0]);
    if (exp_v[1]) chk("m rd_data2", rd2, exp_rd[1]);
  end

  // ---------------- stimulus ----------------
  task automatic set_trig();
    trigger = ($signed(di) >= trig_lo) && ($signed(di) <= trig_hi);
  endtask

  task automatic step();
    @(negedge clk);
    di = di + 1;
    set_trig();
  endtask

  // di is -1 at the start edge so the first write stores 0.
  task automatic do_start(input int pre);
    start    = 1'b1;
    pre_trig = AW'(pre);
    di       = 32'hFFFF_FFFF;
    set_trig();
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(output int j0, output int j2);
    j0 = -1;
    j2 = -1;
    for (int j = 1; j <= 200 && (j0 < 0 || j2 < 0); j++) begin
      step();
      if (done0 && j0 < 0) j0 = j;
      if (done2 && j2 < 0) j2 = j;
    end
  endtask

  task automatic readout(input string tag, input int base, input bit both);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i);
      step();
      chk($sformatf("%s rd0[%0d]", tag, i), rd0, 64'(base + i));
      if (both) chk($sformatf("%s rd2[%0d]", tag, i), rd2, 64'(base + i));
    end
  endtask

  initial begin
    int j0, j2;
    rst = 1'b1; start = 1'b0; trigger = 1'b0; di = '0; pre_trig = '0; rd_addr = '0;
    repeat (3) step();
    chk("reset busy", busy0, 0);
    chk("reset done", done0, 0);
    chk("reset trig_seen", ts0, 0);
    chk("reset rd_data", rd0, 0);
    rst = 1'b0;
    repeat (2) step();

    // pre=4, trigger on sample 10
    trig_lo = 10; trig_hi = 10;
    do_start(4);
    run_until_done(j0, j2);
    chk("s1 done latency", j0, 22);
    chk("s1 sync2 done latency", j2, 24);
    chk("s1 trig_seen", ts0, 1);
    readout("s1", 6, 1);

    // pre=0, trigger on the first armed sample
    trig_lo = 0; trig_hi = 0;
    do_start(0);
    run_until_done(j0, j2);
    chk("s2 done latency", j0, 16);
    chk("s2 sync2 done latency", j2, 18);
    readout("s2", 0, 1);

    // pre=15, trigger held high from start
    trig_lo = -100; trig_hi = 100000;
    do_start(15);
    run_until_done(j0, j2);
    chk("s3 done latency", j0, 16);
    readout("s3", 0, 0);

    // pre=8, trigger after 40 armed cycles: wraps the buffer
    trig_lo = 48; trig_hi = 48;
    do_start(8);
    run_until_done(j0, j2);
    chk("s4 done latency", j0, 56);
    chk("s4 sync2 done latency", j2, 58);
    readout("s4", 40, 1);

    // reset during POST, with an ignored start pulse first
    trig_lo = 10; trig_hi = 10;
    do_start(4);
    for (int j = 0; j < 100 && di != 13; j++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("s5 start ignored busy", busy0, 1);
    chk("s5 start ignored trig_seen", ts0, 1);
    for (int j = 0; j < 100 && di != 15; j++) step();
    rst = 1'b1;
    #1;
    chk("s5 rst busy", busy0, 0);
    chk("s5 rst done", done0, 0);
    chk("s5 rst rd_data", rd0, 0);
    chk("s5 rst trig_seen", ts0, 0);
    chk("s5 rst busy2", busy2, 0);
    chk("s5 rst rd_data2", rd2, 0);
    repeat (2) step();
    rst = 1'b0;
    step();
    do_start(4);
    run_until_done(j0, j2);
    chk("s5 done latency", j0, 22);
    chk("s5 sync2 done latency", j2, 24);
    readout("s5", 6, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
